// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues reads to a synchronous instruction ROM,
// tracks one in-flight read (pend) and one parked word (skid) so that a
// decoder stall never loses or duplicates a word, and stops at HALT_INSN.
//
// Handshake: the fetch issues a read (MemRe=PcEn=1) only in RUN when the
// decoder is not stalling and no Flush/Start is present; a word is delivered
// to the decoder whenever InstrValid=1, and Stall=1 means Instr/InstrPC/
// InstrValid hold for that cycle (the decoder has not consumed them).
module instr_fetch #(
   parameter int             L         = 10,
   parameter int             W         = 9,
   parameter logic [W-1:0]   HALT_INSN = 9'h1FF
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [L-1:0]     ProgCtr,
   input  logic             Stall,
   input  logic             Flush,
   input  logic [W-1:0]     MemData,
   output logic [L-1:0]     MemAddr,
   output logic             MemRe,
   output logic             PcEn,
   output logic [W-1:0]     Instr,
   output logic [L-1:0]     InstrPC,
   output logic             InstrValid,
   output logic             Done,
   output logic [1:0]       StateDbg
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         state;
   logic           pend_v;
   logic [L-1:0]   pend_pc;
   logic           skid_v;
   logic [W-1:0]   skid_data;
   logic [L-1:0]   skid_pc;

   logic           issue;
   logic           load_en;
   logic [W-1:0]   load_word;
   logic [L-1:0]   load_pc;

   assign MemAddr  = ProgCtr;
   assign MemRe    = issue;
   assign PcEn     = issue;
   assign StateDbg = state;

   // Issue decision and selection of the word that would load into Instr
   // (the parked skid word always goes before the word arriving from memory).
   always_comb begin
      issue     = (state == S_RUN) && !Stall && !Flush && !Start;
      load_en   = 1'b0;
      load_word = MemData;
      load_pc   = pend_pc;
      if (skid_v) begin
         load_en   = 1'b1;
         load_word = skid_data;
         load_pc   = skid_pc;
      end else if (pend_v) begin
         load_en   = 1'b1;
      end
   end

   // FSM, fetch pipeline, skid register and decoder-facing outputs.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= S_IDLE;
         pend_v     <= 1'b0;
         pend_pc    <= '0;
         skid_v     <= 1'b0;
         skid_data  <= '0;
         skid_pc    <= '0;
         Instr      <= '0;
         InstrPC    <= '0;
         InstrValid <= 1'b0;
         Done       <= 1'b0;
      end else if (Start) begin
         // Restart from any state; in-flight words are stale
         state      <= S_RUN;
         pend_v     <= 1'b0;
         skid_v     <= 1'b0;
         InstrValid <= 1'b0;
         Done       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               state <= S_IDLE;
            end
            S_DONE: begin
               // Halt word is shown for a single cycle only
               InstrValid <= 1'b0;
            end
            S_RUN: begin
               if (Flush) begin
                  pend_v     <= 1'b0;
                  skid_v     <= 1'b0;
                  InstrValid <= 1'b0;
               end else if (Stall) begin
                  // Park the word arriving from memory; no new reads issue
                  if (pend_v) begin
                     skid_v    <= 1'b1;
                     skid_data <= MemData;
                     skid_pc   <= pend_pc;
                  end
                  pend_v <= 1'b0;
               end else begin
                  pend_v <= issue;
                  if (issue) begin
                     pend_pc <= ProgCtr;
                  end
                  skid_v <= 1'b0;
                  if (load_en) begin
                     Instr      <= load_word;
                     InstrPC    <= load_pc;
                     InstrValid <= 1'b1;
                     if (load_word == HALT_INSN) begin
                        state  <= S_DONE;
                        Done   <= 1'b1;
                        pend_v <= 1'b0;
                     end
                  end else begin
                     InstrValid <= 1'b0;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, stall/skid, flush, halt,
// Start/Flush/Stall priority and reset during a stall.
module tb_instr_fetch;

   localparam int L = 10;
   localparam int W = 9;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic           Clk;
   logic           Reset;
   logic           Start;
   logic [L-1:0]   ProgCtr;
   logic           Stall;
   logic           Flush;
   logic [W-1:0]   MemData;
   logic [L-1:0]   MemAddr;
   logic           MemRe;
   logic           PcEn;
   logic [W-1:0]   Instr;
   logic [L-1:0]   InstrPC;
   logic           InstrValid;
   logic           Done;
   logic [1:0]     StateDbg;

   int n_checks;
   int n_errors;

   logic [W-1:0] rom [1024];

   instr_fetch #(.L(L), .W(W), .HALT_INSN(9'h1FF)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .Start      (Start),
      .ProgCtr    (ProgCtr),
      .Stall      (Stall),
      .Flush      (Flush),
      .MemData    (MemData),
      .MemAddr    (MemAddr),
      .MemRe      (MemRe),
      .PcEn       (PcEn),
      .Instr      (Instr),
      .InstrPC    (InstrPC),
      .InstrValid (InstrValid),
      .Done       (Done),
      .StateDbg   (StateDbg)
   );

   // Clock
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Synchronous instruction ROM model
   always @(posedge Clk) begin
      if (MemRe) MemData <= rom[MemAddr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(input logic st, input logic sl, input logic fl, input logic [L-1:0] pc);
      Start   = st;
      Stall   = sl;
      Flush   = fl;
      ProgCtr = pc;
      #1;
   endtask

   task automatic check_instr(input string tag, input logic [W-1:0] w, input logic [L-1:0] pc);
      check({tag, "_instr"}, 32'(Instr), 32'(w));
      check({tag, "_pc"}, 32'(InstrPC), 32'(pc));
      check({tag, "_valid"}, 32'(InstrValid), 32'd1);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      for (int i = 0; i < 1024; i++) rom[i] = 9'(i + 16);
      MemData = '0;
      Reset = 1'b1;
      Start = 1'b1;
      Stall = 1'b0;
      Flush = 1'b0;
      ProgCtr = '0;

      // Reset held with Start asserted: nothing may issue
      tick();
      check("rst1_memre", 32'(MemRe), 32'd0);
      tick();
      check("rst2_memre", 32'(MemRe), 32'd0);
      check("rst_pcen", 32'(PcEn), 32'd0);
      check("rst_state", 32'(StateDbg), 32'(ST_IDLE));
      check("rst_valid", 32'(InstrValid), 32'd0);
      check("rst_done", 32'(Done), 32'd0);
      check("rst_instr", 32'(Instr), 32'd0);
      check("rst_instrpc", 32'(InstrPC), 32'd0);
      Reset = 1'b0;

      // Stall/Flush in IDLE have no effect
      drive(0, 1, 1, 10'd0);
      check("idle_memre", 32'(MemRe), 32'd0);
      tick();
      check("idle_state", 32'(StateDbg), 32'(ST_IDLE));

      // Streaming
      drive(1, 0, 0, 10'd9);
      check("start_memre", 32'(MemRe), 32'd0);
      tick();
      drive(0, 0, 0, 10'd0);
      check("run_state", 32'(StateDbg), 32'(ST_RUN));
      check("run_memre", 32'(MemRe), 32'd1);
      check("run_addr", 32'(MemAddr), 32'd0);
      check("run_valid0", 32'(InstrValid), 32'd0);
      tick();
      drive(0, 0, 0, 10'd1);
      check("lat_valid", 32'(InstrValid), 32'd0);
      tick();
      drive(0, 0, 0, 10'd2);
      check_instr("s0", 9'h010, 10'd0);
      tick();
      drive(0, 0, 0, 10'd3);
      check_instr("s1", 9'h011, 10'd1);
      tick();
      drive(0, 0, 0, 10'd4);
      check_instr("s2", 9'h012, 10'd2);
      tick();
      drive(0, 0, 0, 10'd5);
      check_instr("s3", 9'h013, 10'd3);
      tick();

      // Stall for three cycles with ProgCtr=5 in flight
      drive(0, 1, 0, 10'd6);
      check("stall1_memre", 32'(MemRe), 32'd0);
      check_instr("stall1", 9'h014, 10'd4);
      tick();
      drive(0, 1, 0, 10'd6);
      check("stall2_memre", 32'(MemRe), 32'd0);
      check_instr("stall2", 9'h014, 10'd4);
      tick();
      drive(0, 1, 0, 10'd6);
      check("stall3_pcen", 32'(PcEn), 32'd0);
      check_instr("stall3", 9'h014, 10'd4);
      tick();
      drive(0, 0, 0, 10'd6);
      check("rel_memre", 32'(MemRe), 32'd1);
      check_instr("rel", 9'h014, 10'd4);
      tick();
      drive(0, 0, 0, 10'd7);
      check_instr("skid5", 9'h015, 10'd5);
      tick();

      // Flush with ProgCtr=7 in flight
      drive(0, 0, 1, 10'd8);
      check("flush_memre", 32'(MemRe), 32'd0);
      check_instr("after6", 9'h016, 10'd6);
      tick();
      drive(0, 0, 0, 10'd40);
      check("fl1_valid", 32'(InstrValid), 32'd0);
      check("fl1_memre", 32'(MemRe), 32'd1);
      tick();
      drive(0, 0, 0, 10'd41);
      check("fl2_valid", 32'(InstrValid), 32'd0);
      tick();
      drive(0, 1, 0, 10'd42);
      check_instr("tgt40", 9'h038, 10'd40);
      tick();

      // Start + Flush + Stall together with the skid full
      drive(1, 1, 1, 10'd42);
      check("pri_memre", 32'(MemRe), 32'd0);
      tick();
      rom[3] = 9'h1FF;
      drive(0, 0, 0, 10'd0);
      check("pri_state", 32'(StateDbg), 32'(ST_RUN));
      check("pri_valid", 32'(InstrValid), 32'd0);
      check("pri_memre2", 32'(MemRe), 32'd1);
      tick();
      drive(0, 0, 0, 10'd1);
      check("pri_noskid", 32'(InstrValid), 32'd0);
      tick();

      // Halt at address 3
      drive(0, 0, 0, 10'd2);
      check_instr("h0", 9'h010, 10'd0);
      tick();
      drive(0, 0, 0, 10'd3);
      check_instr("h1", 9'h011, 10'd1);
      tick();
      drive(0, 0, 0, 10'd4);
      check_instr("h2", 9'h012, 10'd2);
      check("h2_done", 32'(Done), 32'd0);
      tick();
      drive(0, 0, 0, 10'd5);
      check_instr("halt", 9'h1FF, 10'd3);
      check("halt_done", 32'(Done), 32'd1);
      check("halt_state", 32'(StateDbg), 32'(ST_DONE));
      check("halt_memre", 32'(MemRe), 32'd0);
      tick();
      drive(0, 1, 1, 10'd5);
      check("done_valid", 32'(InstrValid), 32'd0);
      check("done_done", 32'(Done), 32'd1);
      check("done_memre", 32'(MemRe), 32'd0);
      check("done_instr", 32'(Instr), 32'h1FF);
      tick();
      drive(0, 0, 0, 10'd5);
      check("done2_state", 32'(StateDbg), 32'(ST_DONE));
      check("done2_done", 32'(Done), 32'd1);
      check("done2_valid", 32'(InstrValid), 32'd0);
      tick();
      rom[3] = 9'h013;
      drive(1, 0, 0, 10'd5);
      tick();
      drive(0, 0, 0, 10'd0);
      check("rs_done", 32'(Done), 32'd0);
      check("rs_state", 32'(StateDbg), 32'(ST_RUN));
      check("rs_memre", 32'(MemRe), 32'd1);
      tick();
      drive(0, 0, 0, 10'd1);
      tick();
      drive(0, 0, 0, 10'd2);
      check_instr("rs0", 9'h010, 10'd0);
      tick();

      // Reset during a two-cycle stall with the skid full
      drive(0, 1, 0, 10'd3);
      tick();
      Reset = 1'b1;
      drive(0, 1, 0, 10'd3);
      tick();
      Reset = 1'b0;
      drive(0, 0, 0, 10'd3);
      check("rr_valid", 32'(InstrValid), 32'd0);
      check("rr_done", 32'(Done), 32'd0);
      check("rr_state", 32'(StateDbg), 32'(ST_IDLE));
      check("rr_memre", 32'(MemRe), 32'd0);
      tick();
      check("rr2_valid", 32'(InstrValid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter L, default 10, instruction address width; matches the program counter width.
REQ-002 Parameter W, default 9, instruction word width.
REQ-003 Parameter HALT_INSN, default 9'h1FF, instruction word that ends a program.
REQ-004 Clk  input  1  clock; all state SHALL change on posedge Clk only.
REQ-005 Reset  input  1  reset, synchronous, active-high.
REQ-006 Start  input  1  begin program; one-cycle pulse, same pulse that clears the program counter.
REQ-007 ProgCtr  input  L  current program counter value.
REQ-008 Stall  input  1  decoder cannot accept a new instruction this cycle.
REQ-009 Flush  input  1  taken jump (je/jne resolved) this cycle; discard in-flight fetches.
REQ-010 MemData  input  W  instruction memory read data, valid one cycle after MemRe=1 (synchronous ROM).
REQ-011 MemAddr  output  L  instruction memory address; equals ProgCtr combinationally.
REQ-012 MemRe  output  1  instruction memory read enable (combinational).
REQ-013 PcEn  output  1  program counter may advance this cycle (combinational).
REQ-014 Instr  output  W  registered instruction presented to the decoder.
REQ-015 InstrPC  output  L  registered address of Instr.
REQ-016 InstrValid  output  1  Instr/InstrPC are valid.
REQ-017 Done  output  1  registered; program has reached HALT_INSN.

Function
REQ-018 The FSM SHALL have states IDLE, RUN and DONE.
- IDLE->RUN on Start.
- RUN->DONE when HALT_INSN loads into Instr.
- DONE->RUN on Start.
- All other cases hold state.
REQ-019 Issue condition: MemRe = PcEn = (state==RUN && !Stall && !Flush && !Start).
REQ-020 Fetch pipeline: on an issue edge, pend_v<=1 and pend_pc<=ProgCtr; otherwise pend_v<=0.
REQ-021 Load latency: a word whose address is issued in cycle t SHALL appear on Instr with InstrValid=1 from the edge ending cycle t+1 when Stall=0 in t+1, giving 2-cycle address-to-Instr latency.
REQ-022 Stall with pend_v=1: MemData and pend_pc SHALL be captured into a 1-entry skid register (skid_v<=1); Instr, InstrPC and InstrValid hold.
REQ-023 Stall with pend_v=0: Instr, InstrPC, InstrValid and skid SHALL hold; no memory reads occur.
REQ-024 First cycle with Stall=0 and skid_v=1: the skid SHALL load into Instr/InstrPC (InstrValid<=1, skid_v<=0) and a new fetch issues in the same cycle.
- Priority for loading Instr: skid before pend.
- skid_v=1 and pend_v=1 with Stall=0 SHALL never coexist.
REQ-025 Stall=0 with no skid and no pend: InstrValid<=0 (bubble).
REQ-026 Flush: pend_v, skid_v and InstrValid SHALL clear at the next edge, and no issue occurs in the Flush cycle.
- The fetch of the jump target begins the following cycle from the new ProgCtr.
- Flush overrides Stall.
REQ-027 Start (any state): same clearing as Flush; Done<=0; state<=RUN.
- Start has priority over Flush, Stall and halt detection.
REQ-028 Halt handling: when HALT_INSN loads into Instr, the following SHALL happen at the same edge:
- state<=DONE, Done<=1.
- pend_v and skid_v cleared.
REQ-029 Halt presentation: the halt word is presented with InstrValid=1 for exactly one cycle. In DONE, InstrValid<=0 at the next edge regardless of Stall.
REQ-030 In IDLE and DONE, MemRe=PcEn=0 and no state except FSM/Done changes without Start.
REQ-031 Flush or Stall in IDLE/DONE SHALL have no effect.
REQ-032 InstrPC width is L; no arithmetic is performed on addresses (wrap-around is owned by the program counter).

Reset
REQ-033 Reset SHALL override all other inputs.
REQ-034 Reset state: state=IDLE; pend_v=skid_v=0; InstrValid=0; Done=0; Instr=0; InstrPC=0.
REQ-035 Reset held for multiple cycles SHALL keep MemRe=PcEn=0.
REQ-036 Reset mid-RUN or mid-stall SHALL discard all in-flight words with none delivered afterward.

Verification
REQ-037 Streaming: Start, ProgCtr 0,1,2,3 on consecutive cycles, ROM[n]=n+9'h010, Stall=0 -> Instr 010,011,012,013 with InstrPC 0..3, InstrValid=1, first valid 2 cycles after ProgCtr=0.
REQ-038 Stall: ProgCtr=5 issued, Stall=1 for 3 cycles, then 0 -> MemRe=0 during stall, Instr holds prior word, then ROM[5] appears with InstrPC=5 one edge after release, no word lost or duplicated.
REQ-039 Flush: issue ProgCtr=7, Flush=1 the next cycle, ProgCtr then 40 -> ROM[7] never valid, MemRe=0 in Flush cycle, ROM[40] appears with InstrPC=40 2 cycles later.
REQ-040 Halt: ROM[3]=9'h1FF during streaming -> Instr=1FF with InstrValid=1 for one cycle, Done=1 thereafter, MemRe=0; Start -> Done=0, fetch resumes at ProgCtr=0.
REQ-041 Priority: Start+Flush+Stall same cycle -> state RUN, all valids clear; Reset during a 2-cycle stall with skid full -> InstrValid=0, Done=0, state IDLE next cycle.
